// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 character-LCD controller.
//   lcd_state_e        - controller FSM states
//   LCD_INIT_SEQ/LEN   - power-up instruction sequence (all written with RS=0)
//   LCD_CMD_CLEAR/HOME - the two slow instructions that need the long execution wait
//   lcd_max            - constant-expression helper for sizing the shared timer
//   lcd_is_long_cmd    - selects the long execution wait for a captured byte
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_IDLE  = 3'd5
  } lcd_state_e;

  localparam int LCD_INIT_LEN = 6;

  // Function set (8-bit, 2 lines) three times, display on, clear, entry mode.
  localparam logic [7:0] LCD_INIT_SEQ [LCD_INIT_LEN] = '{
    8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06
  };

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  function automatic int lcd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Only instructions (RS=0) are slow; a data byte of 0x01/0x02 is an ordinary character.
  function automatic logic lcd_is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter shared by every controller state.
//   clk   - system clock
//   reset - synchronous active-high reset, clears the count
//   load  - load value into the counter (has priority over counting)
//   value - count to load; the owner loads (duration - 1)
//   done  - high while the count is zero
// The counter stops at zero, so done stays high until the next load.
module lcd_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          done
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: byte-wide write port to an HD44780-compatible character LCD.
// After reset it powers the panel, waits T_PWRUP_CYC, replays the init sequence,
// then accepts one write at a time and plays it out with setup / enable-pulse /
// hold / execution timing.
//
// Handshake: a write is accepted at a rising edge where i_valid && o_ready.
// o_ready is registered and drops on the cycle after the accept; i_rs/i_data are
// sampled only on the accept edge, and i_valid while o_ready=0 is ignored (the
// sender holds the request until it is taken).
//
// Ports:
//   i_clk, i_reset      - clock, synchronous active-high reset
//   i_valid, o_ready    - write request / controller idle with init complete
//   i_rs, i_data        - register select (0 = instruction, 1 = data) and byte
//   o_init_done         - init sequence finished (sticky until reset)
//   o_lcd_on            - panel power/backlight enable
//   o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data - LCD pins (RW is always 0)
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP_CYC = 750000,
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 25,
  parameter int T_HOLD_CYC  = 4,
  parameter int T_CMD_CYC   = 2000,
  parameter int T_CLR_CYC   = 82000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic [7:0] o_lcd_data
);

  localparam int T_MAX = lcd_max(lcd_max(lcd_max(T_PWRUP_CYC, T_SETUP_CYC),
                                         lcd_max(T_EN_CYC, T_HOLD_CYC)),
                                 lcd_max(T_CMD_CYC, T_CLR_CYC));
  localparam int CW = $clog2(T_MAX) + 1;

  // Each state is entered with (duration - 1) loaded and leaves on the edge
  // that sees the count at zero, so it occupies exactly 'duration' cycles.
  localparam logic [CW-1:0] LD_PWRUP = CW'(T_PWRUP_CYC - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(T_EN_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_CMD   = CW'(T_CMD_CYC - 1);
  localparam logic [CW-1:0] LD_CLR   = CW'(T_CLR_CYC - 1);

  localparam logic [2:0] LAST_IDX = 3'(LCD_INIT_LEN - 1);

  if ((T_PWRUP_CYC < 1) || (T_SETUP_CYC < 1) || (T_EN_CYC < 1) ||
      (T_HOLD_CYC < 1) || (T_CMD_CYC < 1) || (T_CLR_CYC < 1)) begin : g_bad_timing
    $error("lcd_ctrl: every timing parameter must be at least 1");
  end

  lcd_state_e    state, state_n;
  logic [2:0]    idx, idx_n, idx_inc;
  logic          ready_n, init_done_n, lcd_on_n, rs_n, en_n;
  logic [7:0]    data_n;
  logic          load;
  logic [CW-1:0] load_val;
  logic          done;

  lcd_timer #(.CW(CW)) u_timer (
    .clk   (i_clk),
    .reset (i_reset),
    .load  (load),
    .value (load_val),
    .done  (done)
  );

  assign idx_inc = idx + 3'd1;

  // State register and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_PWRUP;
      idx         <= '0;
      o_ready     <= 1'b0;
      o_init_done <= 1'b0;
      o_lcd_on    <= 1'b0;
      o_lcd_rs    <= 1'b0;
      o_lcd_rw    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_lcd_data  <= 8'h00;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      o_ready     <= ready_n;
      o_init_done <= init_done_n;
      o_lcd_on    <= lcd_on_n;
      o_lcd_rs    <= rs_n;
      o_lcd_rw    <= 1'b0;
      o_lcd_en    <= en_n;
      o_lcd_data  <= data_n;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    ready_n     = 1'b0;
    init_done_n = o_init_done;
    lcd_on_n    = 1'b1;
    rs_n        = o_lcd_rs;
    data_n      = o_lcd_data;
    en_n        = 1'b0;
    load        = 1'b0;
    load_val    = '0;

    case (state)
      S_PWRUP: begin
        // o_lcd_on is still low only in the first cycle out of reset; that is
        // where the power-up wait is started (the timer comes out of reset at 0).
        if (!o_lcd_on) begin
          load     = 1'b1;
          load_val = LD_PWRUP;
        end else if (done) begin
          state_n  = S_SETUP;
          idx_n    = '0;
          rs_n     = 1'b0;
          data_n   = LCD_INIT_SEQ[0];
          load     = 1'b1;
          load_val = LD_SETUP;
        end
      end

      S_SETUP: begin
        if (done) begin
          state_n  = S_PULSE;
          en_n     = 1'b1;
          load     = 1'b1;
          load_val = LD_EN;
        end
      end

      S_PULSE: begin
        en_n = 1'b1;
        if (done) begin
          state_n  = S_HOLD;
          en_n     = 1'b0;
          load     = 1'b1;
          load_val = LD_HOLD;
        end
      end

      S_HOLD: begin
        if (done) begin
          state_n  = S_WAIT;
          load     = 1'b1;
          load_val = lcd_is_long_cmd(o_lcd_rs, o_lcd_data) ? LD_CLR : LD_CMD;
        end
      end

      S_WAIT: begin
        if (done) begin
          if (o_init_done) begin
            state_n = S_IDLE;
            ready_n = 1'b1;
          end else if (idx == LAST_IDX) begin
            state_n     = S_IDLE;
            ready_n     = 1'b1;
            init_done_n = 1'b1;
          end else begin
            state_n  = S_SETUP;
            idx_n    = idx_inc;
            rs_n     = 1'b0;
            data_n   = LCD_INIT_SEQ[idx_inc];
            load     = 1'b1;
            load_val = LD_SETUP;
          end
        end
      end

      S_IDLE: begin
        ready_n = 1'b1;
        if (i_valid && o_ready) begin
          state_n  = S_SETUP;
          ready_n  = 1'b0;
          rs_n     = i_rs;
          data_n   = i_data;
          load     = 1'b1;
          load_val = LD_SETUP;
        end
      end

      default: begin
        state_n = S_PWRUP;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: scenario bench for lcd_ctrl with shortened timing.
// A negedge monitor turns the LCD pins into a log of enable pulses (byte, rise
// cycle, width, setup stability); each scenario task compares that log and the
// handshake timing against values computed from the timing rules.
module tb_lcd_ctrl;

  localparam int T_PWRUP = 20;
  localparam int T_SETUP = 2;
  localparam int T_EN    = 4;
  localparam int T_HOLD  = 2;
  localparam int T_CMD   = 10;
  localparam int T_CLR   = 30;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_valid = 1'b0;
  logic       i_rs = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_ready, o_init_done, o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en;
  logic [7:0] o_lcd_data;

  int tests_run = 0;
  int tests_failed = 0;

  lcd_ctrl #(
    .T_PWRUP_CYC (T_PWRUP),
    .T_SETUP_CYC (T_SETUP),
    .T_EN_CYC    (T_EN),
    .T_HOLD_CYC  (T_HOLD),
    .T_CMD_CYC   (T_CMD),
    .T_CLR_CYC   (T_CLR)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_rs        (i_rs),
    .i_data      (i_data),
    .o_init_done (o_init_done),
    .o_lcd_on    (o_lcd_on),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_en    (o_lcd_en),
    .o_lcd_data  (o_lcd_data)
  );

  // ---------------- clock / cycle count ----------------
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] init_exp [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  logic [8:0] dir_tab  [4] = '{9'h141, 9'h001, 9'h101, 9'h002};

  function automatic int exec_wait(input logic [8:0] b);
    return (b[8] == 1'b0 && (b[7:0] == 8'h01 || b[7:0] == 8'h02)) ? T_CLR : T_CMD;
  endfunction

  // Cycles o_ready stays low after the accept edge.
  function automatic int busy_cycles(input logic [8:0] b);
    return T_SETUP + T_EN + T_HOLD + exec_wait(b);
  endfunction

  // ---------------- pin monitor ----------------
  logic [8:0] byte_q  [$];
  int         rise_q  [$];
  int         width_q [$];
  bit         setup_q [$];
  logic [8:0] exp_q   [$];

  logic       prev_en = 1'b0;
  logic [8:0] prev_byte = '0;
  int         stable_cnt = 0;
  int         width_cnt = 0;
  int         rw_bad = 0;

  always @(negedge i_clk) begin
    logic [8:0] cur;
    cur = {o_lcd_rs, o_lcd_data};
    if (cur == prev_byte) stable_cnt = stable_cnt + 1;
    else stable_cnt = 1;
    prev_byte = cur;
    if (o_lcd_rw !== 1'b0) rw_bad = rw_bad + 1;
    if (o_lcd_en && !prev_en) begin
      byte_q.push_back(cur);
      rise_q.push_back(cyc);
      // RS/DATA unchanged for T_SETUP low-EN samples plus the rising sample.
      setup_q.push_back(stable_cnt >= T_SETUP + 1);
      width_cnt = 0;
    end
    if (o_lcd_en) width_cnt = width_cnt + 1;
    if (!o_lcd_en && prev_en) width_q.push_back(width_cnt);
    prev_en = o_lcd_en;
  end

  task automatic clear_log();
    byte_q.delete(); rise_q.delete(); width_q.delete(); setup_q.delete(); exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  int release_cyc = 0;
  int acc_cyc = 0;
  int low_cnt = 0;
  bit timed_out = 0;

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  // Waits for ready, presents one write, and measures how long ready stays low.
  task automatic do_write(input logic [8:0] b);
    int guard;
    timed_out = 1'b0;
    guard = 0;
    while (!o_ready && guard < 500) begin tick(); guard++; end
    if (!o_ready) begin timed_out = 1'b1; return; end
    i_valid = 1'b1; {i_rs, i_data} = b;
    tick();
    acc_cyc = cyc;
    i_valid = 1'b0; {i_rs, i_data} = 9'($urandom);
    low_cnt = 0;
    while (!o_ready && low_cnt < 500) begin low_cnt++; tick(); end
    if (!o_ready) timed_out = 1'b1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!o_ready && guard < 500) begin tick(); guard++; end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_reset = 1'b1; i_valid = 1'b0;
    repeat (3) tick();
    tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", o_ready); end
    tests_run++; if (o_init_done !== 1'b0) begin tests_failed++; $display("FAIL reset_init_done: got %b want 0", o_init_done); end
    tests_run++; if (o_lcd_on !== 1'b0) begin tests_failed++; $display("FAIL reset_lcd_on: got %b want 0", o_lcd_on); end
    tests_run++; if (o_lcd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_en: got %b want 0", o_lcd_en); end
    tests_run++; if (o_lcd_rs !== 1'b0) begin tests_failed++; $display("FAIL reset_rs: got %b want 0", o_lcd_rs); end
    tests_run++; if (o_lcd_rw !== 1'b0) begin tests_failed++; $display("FAIL reset_rw: got %b want 0", o_lcd_rw); end
    tests_run++; if (o_lcd_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", o_lcd_data); end
    i_reset = 1'b0;
    tick();
    release_cyc = cyc;
    tests_run++; if (o_lcd_on !== 1'b1) begin tests_failed++; $display("FAIL release_lcd_on: got %b want 1", o_lcd_on); end
    tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL release_ready: got %b want 0", o_ready); end
  endtask

  task automatic test_init();
    int guard, done_cyc, n;
    clear_log();
    guard = 0;
    while (o_init_done !== 1'b1 && guard < 2000) begin tick(); guard++; end
    done_cyc = cyc;
    tests_run++; if (o_init_done !== 1'b1) begin tests_failed++; $display("FAIL init_timeout: init_done=%b after %0d cycles", o_init_done, guard); end
    tests_run++; if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL init_ready: got %b want 1", o_ready); end
    tests_run++; if (byte_q.size() != 6) begin tests_failed++; $display("FAIL init_pulse_count: got %0d want 6", byte_q.size()); end
    n = (byte_q.size() < 6) ? byte_q.size() : 6;
    if (width_q.size() < n) n = width_q.size();
    for (int i = 0; i < n; i++) begin
      tests_run++; if (byte_q[i] !== {1'b0, init_exp[i]}) begin tests_failed++; $display("FAIL init_byte%0d: got %h want %h", i, byte_q[i], {1'b0, init_exp[i]}); end
      tests_run++; if (width_q[i] != T_EN) begin tests_failed++; $display("FAIL init_width%0d: got %0d want %0d", i, width_q[i], T_EN); end
      tests_run++; if (setup_q[i] !== 1'b1) begin tests_failed++; $display("FAIL init_setup%0d: RS/DATA not stable %0d cycles before EN", i, T_SETUP); end
      if (i == 0) begin
        tests_run++; if (rise_q[0] != release_cyc + T_PWRUP + T_SETUP) begin tests_failed++; $display("FAIL init_first_rise: got %0d want %0d", rise_q[0] - release_cyc, T_PWRUP + T_SETUP); end
      end else begin
        tests_run++;
        if (rise_q[i] - rise_q[i-1] != T_EN + T_HOLD + exec_wait({1'b0, init_exp[i-1]}) + T_SETUP) begin
          tests_failed++; $display("FAIL init_spacing%0d: got %0d want %0d", i, rise_q[i] - rise_q[i-1], T_EN + T_HOLD + exec_wait({1'b0, init_exp[i-1]}) + T_SETUP);
        end
      end
    end
    if (n == 6) begin
      tests_run++; if (done_cyc != rise_q[5] + T_EN + T_HOLD + T_CMD) begin tests_failed++; $display("FAIL init_done_time: got %0d want %0d", done_cyc - rise_q[5], T_EN + T_HOLD + T_CMD); end
    end
  endtask

  // Directed table first (data 0x41, clear, data 0x01, home), then random bytes.
  task automatic test_writes();
    logic [8:0] b;
    for (int t = 0; t < 16; t++) begin
      if (t < 4) b = dir_tab[t];
      else if ($urandom_range(0, 3) == 0) b = {1'($urandom), 8'($urandom_range(1, 2))};
      else b = 9'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      clear_log();
      do_write(b);
      tests_run++; if (timed_out) begin tests_failed++; $display("FAIL write%0d_timeout: byte %h never completed", t, b); end
      tests_run++; if (low_cnt != busy_cycles(b)) begin tests_failed++; $display("FAIL write%0d_busy: byte %h ready low %0d want %0d", t, b, low_cnt, busy_cycles(b)); end
      tests_run++; if (byte_q.size() != 1 || width_q.size() != 1) begin tests_failed++; $display("FAIL write%0d_pulses: got %0d rises %0d falls want 1", t, byte_q.size(), width_q.size()); end
      if (byte_q.size() >= 1 && width_q.size() >= 1) begin
        tests_run++; if (byte_q[0] !== b) begin tests_failed++; $display("FAIL write%0d_byte: got %h want %h", t, byte_q[0], b); end
        tests_run++; if (rise_q[0] != acc_cyc + T_SETUP) begin tests_failed++; $display("FAIL write%0d_latency: EN rise %0d cycles after accept want %0d", t, rise_q[0] - acc_cyc, T_SETUP); end
        tests_run++; if (width_q[0] != T_EN) begin tests_failed++; $display("FAIL write%0d_width: got %0d want %0d", t, width_q[0], T_EN); end
        tests_run++; if (setup_q[0] !== 1'b1) begin tests_failed++; $display("FAIL write%0d_setup: RS/DATA not stable before EN", t); end
      end
    end
    tests_run++; if (rw_bad != 0) begin tests_failed++; $display("FAIL rw_low: RW seen high %0d cycles want 0", rw_bad); end
  endtask

  // Request held with changing data while busy: only the value on the ready edge goes out.
  task automatic test_hold_busy();
    logic [8:0] cur;
    logic       rdy;
    int         n_acc, guard;
    wait_idle();
    clear_log();
    cur = {1'b1, 8'($urandom)};
    i_valid = 1'b1; {i_rs, i_data} = cur;
    n_acc = 0; guard = 0;
    while (n_acc < 2 && guard < 200) begin
      rdy = o_ready;
      tick(); guard++;
      if (rdy) begin n_acc++; exp_q.push_back(cur); end
      cur = 9'($urandom);
      {i_rs, i_data} = cur;
    end
    i_valid = 1'b0;
    tests_run++; if (n_acc != 2) begin tests_failed++; $display("FAIL hold_accepts: got %0d want 2", n_acc); end
    wait_idle();
    repeat (10) tick();
    tests_run++; if (byte_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL hold_count: got %0d pulses want %0d", byte_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      tests_run++; if (byte_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL hold_byte%0d: got %h want %h", i, byte_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic rdy;
    int   k[2];
    int   n_acc, guard;
    wait_idle();
    clear_log();
    k[0] = 0; k[1] = 0;
    i_valid = 1'b1; {i_rs, i_data} = 9'h148;
    n_acc = 0; guard = 0;
    while (n_acc < 2 && guard < 200) begin
      rdy = o_ready;
      tick(); guard++;
      if (rdy) begin k[n_acc] = cyc; n_acc++; {i_rs, i_data} = 9'h149; end
    end
    i_valid = 1'b0;
    wait_idle();
    tests_run++; if (n_acc != 2) begin tests_failed++; $display("FAIL b2b_accepts: got %0d want 2", n_acc); end
    // Ready is low for busy_cycles after an accept; the next accept is the first edge that sees it high.
    tests_run++; if (k[1] - k[0] != busy_cycles(9'h148) + 1) begin tests_failed++; $display("FAIL b2b_accept_gap: got %0d want %0d", k[1] - k[0], busy_cycles(9'h148) + 1); end
    tests_run++; if (byte_q.size() != 2) begin tests_failed++; $display("FAIL b2b_count: got %0d want 2", byte_q.size()); end
    if (byte_q.size() == 2) begin
      tests_run++; if (byte_q[0] !== 9'h148 || byte_q[1] !== 9'h149) begin tests_failed++; $display("FAIL b2b_bytes: got %h %h want 148 149", byte_q[0], byte_q[1]); end
      tests_run++; if (rise_q[1] - rise_q[0] != busy_cycles(9'h148) + 1) begin tests_failed++; $display("FAIL b2b_spacing: got %0d want %0d", rise_q[1] - rise_q[0], busy_cycles(9'h148) + 1); end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    wait_idle();
    i_valid = 1'b1; {i_rs, i_data} = {1'b1, 8'($urandom)};
    tick();
    i_valid = 1'b0;
    guard = 0;
    while (!o_lcd_en && guard < 20) begin tick(); guard++; end
    tests_run++; if (o_lcd_en !== 1'b1) begin tests_failed++; $display("FAIL midreset_pulse: EN never rose"); end
    i_reset = 1'b1;
    tick();
    tests_run++; if (o_lcd_en !== 1'b0) begin tests_failed++; $display("FAIL midreset_en: got %b want 0", o_lcd_en); end
    tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL midreset_ready: got %b want 0", o_ready); end
    tests_run++; if (o_init_done !== 1'b0) begin tests_failed++; $display("FAIL midreset_init_done: got %b want 0", o_init_done); end
    i_reset = 1'b0;
    tick();
    release_cyc = cyc;
    tests_run++; if (o_lcd_on !== 1'b1) begin tests_failed++; $display("FAIL midreset_lcd_on: got %b want 1", o_lcd_on); end
    test_init();
  endtask

  initial begin
    test_reset();
    test_init();
    test_writes();
    test_hold_busy();
    test_back_to_back();
    test_reset_mid();
    test_writes();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
